simple_source_load: RTL and testbench

Loads a block of 64-bit words from host memory into a local word-addressed memory. It is the read-side counterpart of the result copy path. It requests host reads through the ctrl_* read-master handshake and accepts 512-bit AXI-stream beats. Each beat is unpacked into eight 64-bit words, lane 0 first (bits 63:0). The words are written to consecutive local addresses starting at `offset`. Transfers are chunked to at most 512 words per host request.

---
 rtl/simple_load_pkg.sv | 22 ++
 rtl/beat_unpacker.sv | 54 +++++
 rtl/simple_source_load.sv | 197 +++++++++++++++++++
 tb/tb_simple_source_load.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_load_pkg.sv
// Shared types and constants for the host-to-local source load path.
package simple_load_pkg;

   localparam int MAX_WORDS_NUM_DEFAULT = 512;
   localparam int LANES  = 8;
   localparam int WORD_W = 64;
   localparam int BEAT_W = 512;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      STREAM    = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   // Word count rounded up to a whole number of beats; 33 bits so 2^32-1 words still fits.
   function automatic logic [32:0] round_up8(input logic [31:0] w);
      return ({1'b0, w} + 33'd7) & ~33'd7;
   endfunction

endpackage

// File: rtl/beat_unpacker.sv
// Serialises one 512-bit beat into eight 64-bit words, lane 0 (bits 63:0) first.
// in_load may be asserted only while empty or while the last lane is being emitted.
module beat_unpacker
   import simple_load_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_load,
   input  logic [BEAT_W-1:0] in_data,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic              last_lane,
   output logic              empty
);

   logic [BEAT_W-1:0] hold_q, hold_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic              full_q, full_d;

   always_comb begin
      hold_d    = hold_q;
      lane_d    = lane_q;
      full_d    = full_q;
      out_valid = full_q;
      empty     = !full_q;
      last_lane = full_q && (lane_q == LANE_W'(LANES - 1));
      out_data  = hold_q[lane_q*WORD_W +: WORD_W];

      if (full_q) begin
         lane_d = lane_q + 1'b1;
      end
      // Reloading on the last lane keeps back-to-back beats bubble-free.
      if (in_load) begin
         hold_d = in_data;
         full_d = 1'b1;
         lane_d = '0;
      end else if (last_lane) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
         lane_q <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         lane_q <= lane_d;
         full_q <= full_d;
      end
   end

endmodule

// File: rtl/simple_source_load.sv
// Loads a block of 64-bit words from host memory into local word memory, in host requests
// of at most MAX_WORDS_NUM words. Optional stall counter: define SOURCE_LOAD_PERF_CNT_EN.
// Stream handshake: a beat transfers in a cycle where s_axis_tvalid and s_axis_tready are both high.
module simple_source_load
   import simple_load_pkg::*;
#(
   parameter int MAX_WORDS_NUM = MAX_WORDS_NUM_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              kick,
   output logic              busy,
   input  logic [31:0]       offset,
   input  logic [31:0]       words,
   input  logic [63:0]       memory_addr,
   output logic [31:0]       addr,
   output logic [63:0]       d,
   output logic              we,
   output logic              ctrl_start,
   input  logic              ctrl_done,
   output logic [63:0]       ctrl_addr_offset,
   output logic [63:0]       ctrl_xfer_size_in_bytes,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [BEAT_W-1:0] s_axis_tdata,
`ifdef SOURCE_LOAD_PERF_CNT_EN
   output logic [31:0]       stall_cycles,
`endif
   output logic [1:0]        dbg_state
);

   localparam logic [32:0] MAX_W = 33'(MAX_WORDS_NUM);

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic [31:0] words_left_q, words_left_d;
   logic [32:0] padded_left_q, padded_left_d;
   logic [31:0] addr_q, addr_d;
   logic [63:0] host_addr_q, host_addr_d;
   logic [32:0] chunk_q, chunk_d;
   logic [29:0] beats_left_q, beats_left_d;
   logic        done_seen_q, done_seen_d;
   logic        ctrl_start_q, ctrl_start_d;
   logic [63:0] ctrl_addr_q, ctrl_addr_d;
   logic [63:0] ctrl_size_q, ctrl_size_d;

   logic        tready_c, accept_c, we_c;
   logic [32:0] chunk_sel;
   logic        up_valid, up_last, up_empty;
   logic [63:0] up_data;

   beat_unpacker u_unpacker (
      .clk       (clk),
      .reset     (reset),
      .in_load   (accept_c),
      .in_data   (s_axis_tdata),
      .out_valid (up_valid),
      .out_data  (up_data),
      .last_lane (up_last),
      .empty     (up_empty)
   );

   always_comb begin
      state_d       = state_q;
      words_left_d  = words_left_q;
      padded_left_d = padded_left_q;
      addr_d        = addr_q;
      host_addr_d   = host_addr_q;
      chunk_d       = chunk_q;
      beats_left_d  = beats_left_q;
      done_seen_d   = done_seen_q;
      ctrl_start_d  = 1'b0;
      ctrl_addr_d   = ctrl_addr_q;
      ctrl_size_d   = ctrl_size_q;
      busy_d        = 1'b0;
      chunk_sel     = (padded_left_q > MAX_W) ? MAX_W : padded_left_q;

      tready_c = (state_q == STREAM) && (beats_left_q != '0) && (up_empty || up_last);
      accept_c = s_axis_tvalid && tready_c;
      // Padding lanes past the requested word count are dropped here.
      we_c     = up_valid && (words_left_q != '0);

      if (we_c) begin
         addr_d       = addr_q + 32'd1;
         words_left_d = words_left_q - 32'd1;
      end
      if (accept_c) begin
         beats_left_d = beats_left_q - 30'd1;
      end

      case (state_q)
         IDLE: begin
            if (kick) begin
               words_left_d  = words;
               padded_left_d = round_up8(words);
               addr_d        = offset;
               host_addr_d   = memory_addr;
               busy_d        = 1'b1;
               state_d       = (words == '0) ? IDLE : START;
            end
         end
         START: begin
            chunk_d      = chunk_sel;
            ctrl_size_d  = 64'(chunk_sel) << 3;
            ctrl_addr_d  = host_addr_q;
            ctrl_start_d = 1'b1;
            beats_left_d = chunk_sel[32:3];
            done_seen_d  = 1'b0;
            state_d      = STREAM;
         end
         STREAM: begin
            if (ctrl_done) begin
               done_seen_d = 1'b1;
            end
            if ((beats_left_q == '0) && (up_last || up_empty)) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (done_seen_q || ctrl_done) begin
               padded_left_d = padded_left_q - chunk_q;
               host_addr_d   = host_addr_q + (64'(chunk_q) << 3);
               state_d       = (padded_left_q == chunk_q) ? IDLE : START;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != IDLE) begin
         busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         busy_q        <= 1'b1;
         words_left_q  <= '0;
         padded_left_q <= '0;
         addr_q        <= '0;
         host_addr_q   <= '0;
         chunk_q       <= '0;
         beats_left_q  <= '0;
         done_seen_q   <= 1'b0;
         ctrl_start_q  <= 1'b0;
         ctrl_addr_q   <= '0;
         ctrl_size_q   <= '0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         words_left_q  <= words_left_d;
         padded_left_q <= padded_left_d;
         addr_q        <= addr_d;
         host_addr_q   <= host_addr_d;
         chunk_q       <= chunk_d;
         beats_left_q  <= beats_left_d;
         done_seen_q   <= done_seen_d;
         ctrl_start_q  <= ctrl_start_d;
         ctrl_addr_q   <= ctrl_addr_d;
         ctrl_size_q   <= ctrl_size_d;
      end
   end

`ifdef SOURCE_LOAD_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && kick) begin
         stall_d = '0;
      end else if ((state_q == STREAM) && tready_c && !s_axis_tvalid) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

   assign busy                    = busy_q;
   assign addr                    = addr_q;
   assign d                       = up_data;
   assign we                      = we_c;
   assign ctrl_start              = ctrl_start_q;
   assign ctrl_addr_offset        = ctrl_addr_q;
   assign ctrl_xfer_size_in_bytes = ctrl_size_q;
   assign s_axis_tready           = tready_c;
   assign dbg_state               = state_q;

endmodule

// File: tb/tb_simple_source_load.sv
// Directed bench for simple_source_load: stream source, read-master done responder,
// write scoreboard and request log.
module tb_simple_source_load;

   logic         clk = 1'b0;
   logic         reset;
   logic         kick;
   logic         busy;
   logic [31:0]  offset, words;
   logic [63:0]  memory_addr;
   logic [31:0]  addr;
   logic [63:0]  d;
   logic         we;
   logic         ctrl_start;
   logic         ctrl_done;
   logic [63:0]  ctrl_addr_offset, ctrl_xfer_size_in_bytes;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [511:0] s_axis_tdata;
   logic [1:0]   dbg_state;
`ifdef SOURCE_LOAD_PERF_CNT_EN
   logic [31:0]  stall_cycles;
`endif

   simple_source_load dut (
      .clk                     (clk),
      .reset                   (reset),
      .kick                    (kick),
      .busy                    (busy),
      .offset                  (offset),
      .words                   (words),
      .memory_addr             (memory_addr),
      .addr                    (addr),
      .d                       (d),
      .we                      (we),
      .ctrl_start              (ctrl_start),
      .ctrl_done               (ctrl_done),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
      .s_axis_tvalid           (s_axis_tvalid),
      .s_axis_tready           (s_axis_tready),
      .s_axis_tdata            (s_axis_tdata),
`ifdef SOURCE_LOAD_PERF_CNT_EN
      .stall_cycles            (stall_cycles),
`endif
      .dbg_state               (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_wr     = 0;
   int          gap_cnt  = 0;
   logic [95:0] exp_q[$];
   logic [63:0] req_addr_q[$];
   logic [63:0] req_size_q[$];
   logic [95:0] e;

   // Source / responder controls
   bit          flush = 1'b1;
   bit          src_tog = 1'b0;
   bit          src_early = 1'b0;
   int unsigned src_total = 0;
   int unsigned beat_idx = 0;
   int unsigned target_b = 0;
   int unsigned dly = 0;
   bit          pend = 1'b0;
   bit          acc, st_seen;
   logic [63:0] st_size;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] word_pat(input int unsigned i);
      return {8'hD0, 24'(i * 7), 32'(i)};
   endfunction

   function automatic logic [511:0] make_beat(input int unsigned b);
      logic [511:0] r;
      for (int k = 0; k < 8; k++) r[k*64 +: 64] = word_pat(b * 8 + k);
      return r;
   endfunction

   // Stream source and read-master done responder, stepping once per cycle.
   always begin
      @(negedge clk);
      acc     = s_axis_tvalid && s_axis_tready;
      st_seen = ctrl_start;
      st_size = ctrl_xfer_size_in_bytes;
      @(posedge clk);
      #1;
      if (flush) begin
         beat_idx      = 0;
         pend          = 1'b0;
         ctrl_done     = 1'b0;
         s_axis_tvalid = 1'b0;
      end else begin
         if (st_seen) begin
            pend     = 1'b1;
            target_b = src_early ? beat_idx + 1 : beat_idx + int'(st_size >> 6);
            dly      = src_early ? 0 : 3;
         end
         if (acc) beat_idx++;
         ctrl_done = 1'b0;
         if (pend && beat_idx >= target_b) begin
            if (dly == 0) begin
               ctrl_done = 1'b1;
               pend      = 1'b0;
            end else begin
               dly--;
            end
         end
         if (beat_idx >= src_total) s_axis_tvalid = 1'b0;
         else if (src_tog && s_axis_tvalid && acc) s_axis_tvalid = 1'b0;
         else s_axis_tvalid = 1'b1;
      end
      s_axis_tdata = make_beat(beat_idx);
   end

   // Write scoreboard and request log
   always @(negedge clk) begin
      if (!reset) begin
         if (we) begin
            n_wr++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_val("wr_addr", 64'(addr), 64'(e[95:64]));
               check_val("wr_data", d, e[63:0]);
            end
         end
         if (ctrl_start) begin
            req_addr_q.push_back(ctrl_addr_offset);
            req_size_q.push_back(ctrl_xfer_size_in_bytes);
         end
         if (s_axis_tready && !s_axis_tvalid) gap_cnt++;
      end
   end

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check_val("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic check_req(input int idx, input logic [63:0] a, input logic [63:0] s);
      check_val("req_addr", (req_addr_q.size() > idx) ? req_addr_q[idx] : 64'hDEAD, a);
      check_val("req_size", (req_size_q.size() > idx) ? req_size_q[idx] : 64'hDEAD, s);
   endtask

   task automatic run_load(input logic [31:0] off, input logic [31:0] w, input logic [63:0] maddr,
                           input bit tog, input bit early, input int exp_beats, input bit wait_done);
      flush = 1'b1;
      repeat (2) @(negedge clk);
      src_tog   = tog;
      src_early = early;
      src_total = exp_beats + 2;
      n_wr      = 0;
      gap_cnt   = 0;
      exp_q.delete();
      req_addr_q.delete();
      req_size_q.delete();
      for (int unsigned i = 0; i < w; i++) exp_q.push_back({off + i, word_pat(i)});
      flush = 1'b0;
      @(posedge clk);
      #1;
      kick        = 1'b1;
      offset      = off;
      words       = w;
      memory_addr = maddr;
      @(negedge clk);
      check_val("busy_before_kick", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      kick = 1'b0;
      @(negedge clk);
      check_val("busy_after_kick", 64'(busy), 64'd1);
      check_val("state_start", 64'(dbg_state), 64'd1);
      check_val("start_not_yet", 64'(ctrl_start), 64'd0);
      @(negedge clk);
      check_val("start_pulse", 64'(ctrl_start), 64'd1);
      if (wait_done) begin
         wait_idle(5000);
         check_val("n_writes", 64'(n_wr), 64'(w));
         check_val("exp_left", 64'(exp_q.size()), 64'd0);
         check_val("beats_taken", 64'(beat_idx), 64'(exp_beats));
      end
   endtask

   initial begin
      reset = 1'b1;
      kick = 1'b0;
      offset = '0;
      words = '0;
      memory_addr = '0;
      ctrl_done = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;

      repeat (3) @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd1);
      check_val("rst_start", 64'(ctrl_start), 64'd0);
      check_val("rst_we", 64'(we), 64'd0);
      check_val("rst_tready", 64'(s_axis_tready), 64'd0);
      check_val("rst_addr", 64'(addr), 64'd0);
      check_val("rst_d", d, 64'd0);
      check_val("rst_ctrl_addr", ctrl_addr_offset, 64'd0);
      check_val("rst_ctrl_size", ctrl_xfer_size_in_bytes, 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("post_rst_busy", 64'(busy), 64'd0);
      check_val("post_rst_state", 64'(dbg_state), 64'd0);

      // One beat, one request
      run_load(32'h10, 32'd8, 64'h1000, 1'b0, 1'b0, 1, 1'b1);
      check_val("a_nreq", 64'(req_addr_q.size()), 64'd1);
      check_req(0, 64'h1000, 64'd64);

      // Partial last beat: 13 words, 3 padding lanes dropped
      run_load(32'h40, 32'd13, 64'h2000, 1'b0, 1'b0, 2, 1'b1);
      check_val("b_nreq", 64'(req_addr_q.size()), 64'd1);
      check_req(0, 64'h2000, 64'd128);

      // Two chunks
      run_load(32'h100, 32'd1000, 64'h10000, 1'b0, 1'b0, 125, 1'b1);
      check_val("c_nreq", 64'(req_addr_q.size()), 64'd2);
      check_req(0, 64'h10000, 64'd4096);
      check_req(1, 64'h11000, 64'd3904);

      // Gappy stream
      run_load(32'h300, 32'd20, 64'h3000, 1'b1, 1'b0, 3, 1'b1);
      check_val("d_nreq", 64'(req_addr_q.size()), 64'd1);
      check_req(0, 64'h3000, 64'd192);
`ifdef SOURCE_LOAD_PERF_CNT_EN
      check_val("stall_cycles", 64'(stall_cycles), 64'(gap_cnt));
`endif

      // ctrl_done well before the last beat of each chunk
      run_load(32'h800, 32'd600, 64'h40000, 1'b0, 1'b1, 75, 1'b1);
      check_val("e_nreq", 64'(req_addr_q.size()), 64'd2);
      check_req(0, 64'h40000, 64'd4096);
      check_req(1, 64'h41000, 64'd704);

      // Local address wraps modulo 2^32
      run_load(32'hFFFF_FFFC, 32'd8, 64'h0, 1'b0, 1'b0, 1, 1'b1);
      check_req(0, 64'h0, 64'd64);

      // Zero-word kick: one busy cycle, no request
      req_addr_q.delete();
      n_wr = 0;
      @(posedge clk);
      #1;
      kick  = 1'b1;
      words = 32'd0;
      @(posedge clk);
      #1;
      kick = 1'b0;
      @(negedge clk);
      check_val("zero_busy", 64'(busy), 64'd1);
      check_val("zero_state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      check_val("zero_busy_drop", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check_val("zero_nreq", 64'(req_addr_q.size()), 64'd0);
      check_val("zero_nwr", 64'(n_wr), 64'd0);

      // Reset in the middle of a stream, then a fresh load
      run_load(32'h100, 32'd1000, 64'h10000, 1'b0, 1'b0, 125, 1'b0);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (n_wr >= 20) break;
      end
      check_val("mid_progress", 64'(n_wr >= 20), 64'd1);
      #2;
      reset = 1'b1;
      flush = 1'b1;
      #1;
      check_val("mid_rst_we", 64'(we), 64'd0);
      check_val("mid_rst_tready", 64'(s_axis_tready), 64'd0);
      check_val("mid_rst_start", 64'(ctrl_start), 64'd0);
      check_val("mid_rst_busy", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("mid_post_busy", 64'(busy), 64'd0);
      check_val("mid_post_state", 64'(dbg_state), 64'd0);
      run_load(32'h200, 32'd8, 64'h8000, 1'b0, 1'b0, 1, 1'b1);
      check_val("g_nreq", 64'(req_addr_q.size()), 64'd1);
      check_req(0, 64'h8000, 64'd64);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
